// File: rtl/unpacked_array_fifo_pkg.sv
// Shared widths and types for the unpacked-array FIFO slice.
// Package-level values describe the default build (M=2, DEPTH=4); modules derive their own via the functions.
// No state; no flow control.
package unpacked_array_fifo_pkg;

    localparam int DEF_M     = 2;
    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = $clog2(DEF_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef logic [DEF_M-1:0] word_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the occupancy can represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/unpacked_array_fifo_ptr.sv
// Wrapping W-bit pointer for the FIFO store; DEPTH is a power of two so natural overflow wraps.
// Latency: pointer advances on the clock edge where inc is high.
// Backpressure: none; the caller only raises inc for accepted transfers.
module fifo_ptr
    import unpacked_array_fifo_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clock,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/unpacked_array_fifo.sv
// Elastic input stage: buffers M-bit words in an unpacked store and returns them in order.
// Latency: rd_data/rd_valid registered, one cycle after an accepted read; no write-to-read bypass.
// Backpressure: writes rejected when full unless a read is accepted in the same cycle; flags sticky errors.
module unpacked_array_fifo
    import unpacked_array_fifo_pkg::*;
#(
    parameter int M     = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [M-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [M-1:0]               rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    typedef logic [M-1:0] mword_t;

    mword_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wa;
    logic          ra;
    logic          ovf_evt;
    logic          udf_evt;
    logic [CW-1:0] count_nxt;

    // A read frees a slot in the same cycle, so a write into a full FIFO is still taken.
    always_comb begin
        ra        = rd_en && !empty;
        wa        = wr_en && (!full || ra);
        ovf_evt   = wr_en && full && !rd_en;
        udf_evt   = rd_en && empty;
        count_nxt = count + CW'(wa) - CW'(ra);
    end

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clock (clock),
        .rstn  (rstn),
        .inc   (wa),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clock (clock),
        .rstn  (rstn),
        .inc   (ra),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wa) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ra;
            if (ra) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

    // A fresh error in the same cycle takes priority over clear_err.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clear_err) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clear_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
